// File: rtl/scan_pkg.sv
// Shared scan-chain definitions: loader FSM encoding and default chain geometry
// (the default geometry must match the overlay build).
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  localparam int DEF_WORD_WIDTH   = 8;
  localparam int DEF_CHAIN_LENGTH = 20;

endpackage

// File: rtl/scan_capture.sv
// SOUT deserializer: packs captured chain bits LSB-first into words and strobes RVALID;
// a flush emits a partially filled word with its unfilled MSBs zero.
module scan_capture
  import scan_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  sout,
  input  logic                  flush,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] cap_q, cap_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;

  always_comb begin
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (cap_en) begin
      if (cnt_q == LAST) begin
        rdata_d        = cap_q;
        rdata_d[cnt_q] = sout;
        rvalid_d       = 1'b1;
        cap_d          = '0;
        cnt_d          = '0;
      end else begin
        cap_d[cnt_q] = sout;
        cnt_d        = cnt_q + 1'b1;
      end
    end else if (flush && (cnt_q != '0)) begin
      // cap_q is cleared at every word boundary, so unfilled bits are already zero
      rdata_d  = cap_q;
      rvalid_d = 1'b1;
      cap_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/scan_loader.sv
// Host-driven scan loader: accepts words over valid/ready, shifts exactly CHAIN_LENGTH bits
// LSB-first onto registered SE/SIN, and captures SOUT into readback words.
module scan_loader
  import scan_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int CNT_W        = 16
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  START,
  input  logic [WORD_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  SE,
  output logic                  SIN,
  input  logic                  SOUT,
  output logic [WORD_WIDTH-1:0] RDATA,
  output logic                  RVALID,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int               WB_W  = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] WW_C  = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LENGTH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [WB_W-1:0]  WB1_C = WB_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [WB_W-1:0]       wbits_q, wbits_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  se_q, se_d;
  logic                  sin_q, sin_d;

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wbits_q     <= '0;
      shreg_q     <= '0;
      se_q        <= 1'b0;
      sin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wbits_q     <= wbits_d;
      shreg_q     <= shreg_d;
      se_q        <= se_d;
      sin_q       <= sin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (START) state_d = ST_WAIT_WORD;
      ST_WAIT_WORD: if (DATA_VALID) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (remaining_q == ONE_C)  state_d = ST_FINISH;
        else if (wbits_q == WB1_C) state_d = ST_WAIT_WORD;
      end
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // SE/SIN are registered, so the bit for the next cycle is chosen here: the first bit is
  // launched at acceptance and each SHIFT cycle launches the following one.
  always_comb begin
    remaining_d = remaining_q;
    wbits_d     = wbits_q;
    shreg_d     = shreg_q;
    se_d        = 1'b0;
    sin_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) remaining_d = LEN_C;
      end
      ST_WAIT_WORD: begin
        if (DATA_VALID) begin
          shreg_d = DATA_IN >> 1;
          wbits_d = (remaining_q < WW_C) ? WB_W'(remaining_q) : WB_W'(WORD_WIDTH);
          se_d    = 1'b1;
          sin_d   = DATA_IN[0];
        end
      end
      ST_SHIFT: begin
        remaining_d = remaining_q - ONE_C;
        wbits_d     = wbits_q - WB1_C;
        if ((remaining_q != ONE_C) && (wbits_q != WB1_C)) begin
          se_d    = 1'b1;
          sin_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    DATA_READY = (state_q == ST_WAIT_WORD);
    BUSY       = (state_q != ST_IDLE);
    DONE       = (state_q == ST_FINISH);
    SE         = se_q;
    SIN        = sin_q;
  end

  scan_capture #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_capture (
    .clk    (PCLK),
    .rst    (PRST),
    .cap_en (se_q),
    .sout   (SOUT),
    .flush  (state_q == ST_FINISH),
    .rdata  (RDATA),
    .rvalid (RVALID)
  );

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader: a 20-bit chain instance driven through several load scenarios
// and an 8-bit chain instance for the single-word case; SOUT loops back from SIN.
module tb_scan_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       prst;
  logic       start_a, dval_a, drdy_a, se_a, sin_a, sout_a, rvalid_a, busy_a, done_a;
  logic [7:0] din_a, rdata_a;
  logic       start_b, dval_b, drdy_b, se_b, sin_b, sout_b, rvalid_b, busy_b, done_b;
  logic [7:0] din_b, rdata_b;

  scan_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .CNT_W(16)) dut_a (
    .PCLK(clk), .PRST(prst), .START(start_a), .DATA_IN(din_a), .DATA_VALID(dval_a),
    .DATA_READY(drdy_a), .SE(se_a), .SIN(sin_a), .SOUT(sout_a), .RDATA(rdata_a),
    .RVALID(rvalid_a), .BUSY(busy_a), .DONE(done_a)
  );

  scan_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(8), .CNT_W(16)) dut_b (
    .PCLK(clk), .PRST(prst), .START(start_b), .DATA_IN(din_b), .DATA_VALID(dval_b),
    .DATA_READY(drdy_b), .SE(se_b), .SIN(sin_b), .SOUT(sout_b), .RDATA(rdata_b),
    .RVALID(rvalid_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Chain tail follows SIN half a cycle later, so each capture edge sees the bit just shifted.
  always @(negedge clk) begin
    sout_a = sin_a;
    sout_b = sin_b;
  end

  int checks = 0;
  int errors = 0;

  logic       exp_sin_q[$];
  logic [7:0] exp_rd_q[$];
  int         se_cnt = 0, done_cnt = 0, acc_cnt = 0;
  logic       prev_se = 1'b0;
  int         se_cnt_b = 0, ones_b = 0, rv_cnt_b = 0, done_cnt_b = 0;
  logic [7:0] last_rd_b = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for instance A: SIN bits and readback words are popped as the DUT produces them.
  always @(negedge clk) begin
    if (dval_a && drdy_a) acc_cnt++;
    if (se_a) begin
      se_cnt++;
      check("sin_queue_nonempty", 32'(exp_sin_q.size() != 0), 32'd1);
      if (exp_sin_q.size() != 0) check("sin_bit", 32'(sin_a), 32'(exp_sin_q.pop_front()));
    end
    if (rvalid_a) begin
      check("rdata_queue_nonempty", 32'(exp_rd_q.size() != 0), 32'd1);
      if (exp_rd_q.size() != 0) check("rdata", 32'(rdata_a), 32'(exp_rd_q.pop_front()));
    end
    if (done_a) begin
      done_cnt++;
      check("done_after_last_bit", 32'({prev_se, se_a}), 32'b10);
    end
    prev_se = se_a;
    if (se_b) begin
      se_cnt_b++;
      if (sin_b) ones_b++;
    end
    if (rvalid_b) begin
      rv_cnt_b++;
      last_rd_b = rdata_b;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one word after an optional stall; returns one cycle after the accepting edge.
  task automatic send_word(input logic [7:0] w, input int gap);
    int t;
    if (gap > 0) begin
      dval_a = 1'b0;
      repeat (gap) cycle();
    end
    din_a  = w;
    dval_a = 1'b1;
    t = 0;
    while (!drdy_a && t < 40) begin
      cycle();
      t++;
    end
    check("ready_wait_bounded", 32'(t < 40), 32'd1);
    cycle();
    @(negedge clk);
    check("ready_drops_after_accept", 32'(drdy_a), 32'd0);
    check("se_cycle_after_accept", 32'(se_a), 32'd1);
    cycle();
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int gap, input bit dup_start);
    logic [23:0] wv;
    int s0, d0, a0, t;
    wv = {w2, w1, w0};
    for (int i = 0; i < 20; i++) exp_sin_q.push_back(wv[i]);
    exp_rd_q.push_back(w0);
    exp_rd_q.push_back(w1);
    exp_rd_q.push_back({4'h0, w2[3:0]});
    s0 = se_cnt;
    d0 = done_cnt;
    a0 = acc_cnt;
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    if (dup_start) begin
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
    end
    send_word(w0, 0);
    send_word(w1, gap);
    if (dup_start) begin
      start_a = 1'b1;
      cycle();
      start_a = 1'b0;
    end
    send_word(w2, gap);
    dval_a = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 60) begin
      cycle();
      t++;
    end
    check("done_wait_bounded", 32'(t < 60), 32'd1);
    repeat (4) cycle();
    check("se_cycles", 32'(se_cnt - s0), 32'd20);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("words_accepted", 32'(acc_cnt - a0), 32'd3);
    check("sin_queue_drained", 32'(exp_sin_q.size()), 32'd0);
    check("rdata_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("idle_after_load", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int t;
    prst = 1'b1;
    start_a = 1'b0; dval_a = 1'b0; din_a = 8'h00;
    start_b = 1'b0; dval_b = 1'b0; din_b = 8'h00;
    repeat (3) cycle();
    @(negedge clk);
    check("rst_se", 32'(se_a), 32'd0);
    check("rst_sin", 32'(sin_a), 32'd0);
    check("rst_ready", 32'(drdy_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_rvalid", 32'(rvalid_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    cycle();
    prst = 1'b0;
    cycle();

    // Back-to-back words with VALID held high
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);
    // Five-cycle source stall between words
    run_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0);
    // Repeated START in WAIT_WORD and during SHIFT
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b1);

    // Reset three bits into word 2: eight bits of 0xA5 then 0x3C bits 0..2
    for (int i = 0; i < 8; i++) exp_sin_q.push_back(i == 0 || i == 2 || i == 5 || i == 7);
    exp_sin_q.push_back(1'b0);
    exp_sin_q.push_back(1'b0);
    exp_sin_q.push_back(1'b1);
    exp_rd_q.push_back(8'hA5);
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    dval_a = 1'b0;
    cycle();
    prst = 1'b1;
    cycle();
    prst = 1'b0;
    @(negedge clk);
    check("midload_rst_se", 32'(se_a), 32'd0);
    check("midload_rst_busy", 32'(busy_a), 32'd0);
    check("midload_rst_ready", 32'(drdy_a), 32'd0);
    check("midload_sin_drained", 32'(exp_sin_q.size()), 32'd0);
    check("midload_rdata_drained", 32'(exp_rd_q.size()), 32'd0);
    cycle();
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0);

    // Single-word chain on the 8-bit instance
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    din_b  = 8'hFF;
    dval_b = 1'b1;
    t = 0;
    while (!drdy_b && t < 40) begin
      cycle();
      t++;
    end
    check("b_ready_wait_bounded", 32'(t < 40), 32'd1);
    cycle();
    dval_b = 1'b0;
    t = 0;
    while (done_cnt_b == 0 && t < 40) begin
      cycle();
      t++;
    end
    check("b_done_wait_bounded", 32'(t < 40), 32'd1);
    repeat (4) cycle();
    check("b_se_cycles", 32'(se_cnt_b), 32'd8);
    check("b_sin_ones", 32'(ones_b), 32'd8);
    check("b_rvalid_count", 32'(rv_cnt_b), 32'd1);
    check("b_rdata", 32'(last_rd_b), 32'hFF);
    check("b_done_count", 32'(done_cnt_b), 32'd1);
    check("b_idle", 32'(busy_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
